seq_mult: RTL

Sequential shift-add unsigned multiplier, the companion to the team's shift-subtract divider in the arithmetic datapath. A single start pulse loads two N-bit operands. The block then retires one multiplier bit per clock and presents a 2N-bit product with a one-cycle done strobe. It shares the divider's start/busy/done handshake so the same controller can drive either unit.

---
 rtl/seq_mult_pkg.sv | 19 +
 rtl/seq_mult_step.sv | 23 ++
 rtl/seq_mult.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared arithmetic datapath definitions: controller state encoding common to the
// sequential multiplier and divider, default operand width, counter sizing helper.
package seq_mult_pkg;

  localparam int unsigned ARITH_W_DEFAULT = 8;

  // Encoding is shared with the divider controller; keep values stable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } arith_state_e;

  // Bits needed to hold an iteration count from n down to 0.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One shift-add iteration: conditionally add M to the upper half, then shift {ACC, Q} right.
// Purely combinational; the carry lands in ACC[N] before the shift so nothing is lost.
module seq_mult_step
  import seq_mult_pkg::*;
#(
  parameter int unsigned N = ARITH_W_DEFAULT
) (
  input  logic [N:0]   acc,
  input  logic [N-1:0] q,
  input  logic [N-1:0] m,
  output logic [N:0]   acc_nxt,
  output logic [N-1:0] q_nxt
);

  logic [N:0] sum;

  always_comb begin
    sum     = acc + (q[0] ? {1'b0, m} : '0);
    acc_nxt = {1'b0, sum[N:1]};
    q_nxt   = {sum[0], q[N-1:1]};
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add unsigned multiplier: N-cycle latency from accept to done, one bit per clock.
// start is honoured only in IDLE/DONE (held start gives back-to-back products every N+1 cycles).
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned N = ARITH_W_DEFAULT
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = cnt_width(N);

  arith_state_e   state_q, state_d;
  logic [N-1:0]   m_q, m_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N:0]     step_acc;
  logic [N-1:0]   step_q;

  seq_mult_step #(.N(N)) u_step (
    .acc     (acc_q),
    .q       (q_q),
    .m       (m_q),
    .acc_nxt (step_acc),
    .q_nxt   (step_q)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          m_d     = a;
          acc_d   = '0;
          q_d     = b;
          cnt_d   = CW'(N);
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here: no queueing, operands not sampled.
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = {step_acc[N-1:0], step_q};
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
